// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state codes, legal
// oversampling ratios and the strobe offset past mid-bit.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // The majority sampler finishes at P/2+1, so its result is stable here.
    localparam int unsigned STROBE_OFS = 2;

    function automatic int unsigned legal_prescale(input int unsigned p);
        return (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter (wraps at i_edge_max) and data-bit counter.
// Both registered; edge counter held at 0 while disabled.
module edge_bit_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_edge_en,
    input  logic [PRESCALE_W-1:0] i_edge_max,
    input  logic                  i_bit_inc,
    input  logic                  i_bit_clr,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic                  o_edge_last,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  w_edge_last;

    assign w_edge_last = i_edge_en && (r_edge_cnt == i_edge_max);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (!i_edge_en || w_edge_last) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end

            if (i_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (i_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    assign o_edge_cnt  = r_edge_cnt;
    assign o_edge_last = w_edge_last;
    assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, bit sequencing, checker windows and
// a single-cycle data_valid at the end of an error-free stop bit.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_rx_in,
    input  logic                  i_par_en,
    input  logic                  i_strt_glitch,
    input  logic                  i_par_err,
    input  logic                  i_stop_err,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_data_samp_en,
    output logic                  o_deser_en,
    output logic                  o_strt_chk_en,
    output logic                  o_par_chk_en,
    output logic                  o_stop_chk_en,
    output logic                  o_data_valid,
    output logic                  o_busy
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    logic [2:0]            r_state;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_flag;
    logic                  r_busy;

    logic [PRESCALE_W-1:0] w_edge_cnt;
    logic [PRESCALE_W-1:0] w_edge_max;
    logic [PRESCALE_W-1:0] w_strobe;
    logic [BIT_CNT_W-1:0]  w_bit_cnt;
    logic                  w_last;
    logic                  w_past_strobe;
    logic                  w_bit_final;
    logic                  w_in_data;

    assign w_edge_max    = r_prescale - PRESCALE_W'(1);
    assign w_strobe      = (r_prescale >> 1) + PRESCALE_W'(STROBE_OFS);
    assign w_past_strobe = (w_edge_cnt >= w_strobe);
    assign w_bit_final   = (w_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
    assign w_in_data     = (r_state == ST_DATA);

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_edge_en   (r_state != ST_IDLE),
        .i_edge_max  (w_edge_max),
        .i_bit_inc   (w_in_data && w_last && !w_bit_final),
        .i_bit_clr   (!w_in_data || (w_last && w_bit_final)),
        .o_edge_cnt  (w_edge_cnt),
        .o_edge_last (w_last),
        .o_bit_cnt   (w_bit_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_prescale <= PRESCALE_W'(PRESCALE_8);
            r_par_flag <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_rx_in) begin
                        r_state    <= ST_START;
                        r_busy     <= 1'b1;
                        r_prescale <= PRESCALE_W'(legal_prescale(32'(i_prescale)));
                    end
                end
                ST_START: begin
                    if (w_last) begin
                        if (i_strt_glitch) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_last && w_bit_final) begin
                        r_state <= i_par_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    // The parity checker clears once its window closes, so keep the verdict here.
                    if (w_last) begin
                        r_par_flag <= i_par_err;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_last) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_par_flag <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_edge_cnt     = w_edge_cnt;
    assign o_bit_cnt      = w_bit_cnt;
    assign o_busy         = r_busy;
    assign o_data_samp_en = r_busy;
    assign o_deser_en     = w_in_data && (w_edge_cnt == w_strobe);
    assign o_strt_chk_en  = (r_state == ST_START)  && w_past_strobe;
    assign o_par_chk_en   = (r_state == ST_PARITY) && w_past_strobe;
    assign o_stop_chk_en  = (r_state == ST_STOP)   && w_past_strobe;
    assign o_data_valid   = (r_state == ST_STOP) && w_last && !i_stop_err && !r_par_flag;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomised frame-level bench for uart_rx_fsm against a bit-position model.
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;
    localparam int BW = 4;
    localparam int OW = PW + BW + 7;

    logic          clk;
    logic          rst;
    logic [PW-1:0] prescale;
    logic          rx_in;
    logic          par_en;
    logic          strt_glitch;
    logic          par_err;
    logic          stop_err;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          data_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stop_chk_en;
    logic          data_valid;
    logic          busy;
    logic [OW-1:0] w_obs;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        int            mism;
        int            first_t;
        logic [OW-1:0] first_obs;
        logic [OW-1:0] first_exp;
        logic [OW-1:0] idle_obs;
        int            deser_n;
        int            dv_n;
        int            dv_t;
        int            len;
    } res_t;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_prescale     (prescale),
        .i_rx_in        (rx_in),
        .i_par_en       (par_en),
        .i_strt_glitch  (strt_glitch),
        .i_par_err      (par_err),
        .i_stop_err     (stop_err),
        .o_edge_cnt     (edge_cnt),
        .o_bit_cnt      (bit_cnt),
        .o_data_samp_en (data_samp_en),
        .o_deser_en     (deser_en),
        .o_strt_chk_en  (strt_chk_en),
        .o_par_chk_en   (par_chk_en),
        .o_stop_chk_en  (stop_chk_en),
        .o_data_valid   (data_valid),
        .o_busy         (busy)
    );

    assign w_obs = {edge_cnt, bit_cnt, busy, data_samp_en, deser_en,
                    strt_chk_en, par_chk_en, stop_chk_en, data_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
        end
    endtask

    // Drives one frame starting from IDLE and compares every cycle against the
    // position model: t cycles after detection, bit t/P, oversample t%P.
    task automatic run_frame(input int p_in, input int p_mid, input bit par0, input bit par1,
                             input logic [DW-1:0] d, input bit glitch, input bit perr,
                             input bit serr, input int abort_t, output res_t r);
        int pe, s, nb, len, bi, e, bitc;
        logic [OW-1:0] ex;
        pe = (p_in == 8 || p_in == 16 || p_in == 32) ? p_in : 8;
        s  = pe / 2 + 2;
        nb = glitch ? 1 : (2 + DW + int'(par1));
        len = nb * pe;
        r.mism = 0; r.first_t = -1; r.first_obs = '0; r.first_exp = '0;
        r.deser_n = 0; r.dv_n = 0; r.dv_t = -1; r.len = 0;

        @(negedge clk);
        prescale = PW'(p_in); par_en = par0; rx_in = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
        #1 r.idle_obs = w_obs;

        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            bi = t / pe;
            e  = t % pe;
            if (t == 3 * pe) begin
                prescale = PW'(p_mid);
                par_en   = par1;
            end
            if (glitch)               rx_in = (t < 2) ? 1'b0 : 1'b1;
            else if (bi == 0)         rx_in = 1'b0;
            else if (bi <= DW)        rx_in = d[bi-1];
            else if (par1 && bi == DW + 1) rx_in = ^d;
            else                      rx_in = 1'b1;
            strt_glitch = glitch && bi == 0 && e >= s;
            par_err     = perr && par1 && bi == DW + 1 && e >= s;
            stop_err    = serr && !glitch && bi == nb - 1 && e >= s;
            #1;
            bitc = (bi >= 1 && bi <= DW) ? bi - 1 : 0;
            ex = {PW'(e), BW'(bitc), 1'b1, 1'b1,
                  1'(bi >= 1 && bi <= DW && e == s),
                  1'(bi == 0 && e >= s),
                  1'(par1 && !glitch && bi == DW + 1 && e >= s),
                  1'(!glitch && bi == nb - 1 && e >= s),
                  1'(!glitch && t == len - 1 && !serr && !(par1 && perr))};
            if (w_obs !== ex) begin
                if (r.mism == 0) begin
                    r.first_t = t; r.first_obs = w_obs; r.first_exp = ex;
                end
                r.mism++;
            end
            if (deser_en)   r.deser_n++;
            if (data_valid) begin r.dv_n++; r.dv_t = t; end
            if (busy)       r.len++;
            if (t == abort_t) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; rx_in = 1'b0; prescale = 6'd8; par_en = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (w_obs !== '0) begin
            n_errs++; $display("FAIL reset_outputs got=%h exp=0", w_obs);
        end
        rst = 1'b1; rx_in = 1'b1;
        idle(2);
        #1;
        n_checks++;
        if (w_obs !== '0) begin
            n_errs++; $display("FAIL idle_after_reset got=%h exp=0", w_obs);
        end
    endtask

    task automatic test_basic_p8;
        res_t r;
        run_frame(8, 8, 0, 0, 8'hA5, 0, 0, 0, -1, r);
        n_checks++;
        if (r.mism !== 0) begin
            n_errs++; $display("FAIL p8_cycles mism=%0d t=%0d got=%h exp=%h", r.mism, r.first_t, r.first_obs, r.first_exp);
        end
        n_checks++;
        if (r.deser_n !== DW) begin
            n_errs++; $display("FAIL p8_deser_count got=%0d exp=%0d", r.deser_n, DW);
        end
        n_checks++;
        if (r.dv_n !== 1 || r.dv_t !== 79) begin
            n_errs++; $display("FAIL p8_data_valid count=%0d at=%0d exp 1 at 79", r.dv_n, r.dv_t);
        end
        idle(1);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errs++; $display("FAIL p8_busy_fall got=%b exp=0", busy);
        end
    endtask

    task automatic test_parity_err;
        res_t r;
        run_frame(16, 16, 1, 1, 8'h3C, 0, 1, 0, -1, r);
        n_checks++;
        if (r.mism !== 0) begin
            n_errs++; $display("FAIL par_cycles mism=%0d t=%0d got=%h exp=%h", r.mism, r.first_t, r.first_obs, r.first_exp);
        end
        n_checks++;
        if (r.dv_n !== 0 || r.len !== 176) begin
            n_errs++; $display("FAIL par_err_frame dv=%0d len=%0d exp dv=0 len=176", r.dv_n, r.len);
        end
        idle(2);
    endtask

    task automatic test_glitch;
        res_t r;
        run_frame(8, 8, 0, 0, 8'h00, 1, 0, 0, -1, r);
        n_checks++;
        if (r.mism !== 0) begin
            n_errs++; $display("FAIL glitch_cycles mism=%0d t=%0d got=%h exp=%h", r.mism, r.first_t, r.first_obs, r.first_exp);
        end
        n_checks++;
        if (r.deser_n !== 0 || r.dv_n !== 0 || r.len !== 8) begin
            n_errs++; $display("FAIL glitch_abort deser=%0d dv=%0d len=%0d exp 0 0 8", r.deser_n, r.dv_n, r.len);
        end
        idle(1);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errs++; $display("FAIL glitch_idle busy=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back;
        res_t r1, r2;
        run_frame(8, 8, 0, 0, 8'h5A, 0, 0, 1, -1, r1);
        run_frame(8, 8, 0, 0, 8'hC3, 0, 0, 0, -1, r2);
        n_checks++;
        if (r1.mism !== 0 || r1.dv_n !== 0) begin
            n_errs++; $display("FAIL b2b_stop_err mism=%0d dv=%0d exp 0 0", r1.mism, r1.dv_n);
        end
        n_checks++;
        if (r2.idle_obs !== '0) begin
            n_errs++; $display("FAIL b2b_idle_gap got=%h exp=0", r2.idle_obs);
        end
        n_checks++;
        if (r2.mism !== 0 || r2.dv_n !== 1) begin
            n_errs++; $display("FAIL b2b_second mism=%0d dv=%0d exp 0 1", r2.mism, r2.dv_n);
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        res_t r;
        run_frame(8, 8, 0, 0, 8'h96, 0, 0, 0, 8 * 4 + 2, r);
        @(negedge clk);
        rst = 1'b1; rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
        #1;
        n_checks++;
        if (w_obs !== '0 || r.mism !== 0 || r.dv_n !== 0) begin
            n_errs++; $display("FAIL reset_mid got=%h mism=%0d dv=%0d exp 0 0 0", w_obs, r.mism, r.dv_n);
        end
        run_frame(8, 8, 1, 1, 8'h71, 0, 0, 0, -1, r);
        n_checks++;
        if (r.mism !== 0 || r.dv_n !== 1 || r.len !== 88) begin
            n_errs++; $display("FAIL after_reset_frame mism=%0d dv=%0d len=%0d exp 0 1 88", r.mism, r.dv_n, r.len);
        end
        idle(2);
    endtask

    task automatic test_prescale;
        res_t r;
        run_frame(12, 12, 0, 0, 8'hE1, 0, 0, 0, -1, r);
        n_checks++;
        if (r.mism !== 0 || r.dv_n !== 1 || r.len !== 80) begin
            n_errs++; $display("FAIL illegal_prescale mism=%0d dv=%0d len=%0d exp 0 1 80", r.mism, r.dv_n, r.len);
        end
        run_frame(8, 16, 0, 0, 8'h1E, 0, 0, 0, -1, r);
        n_checks++;
        if (r.mism !== 0 || r.dv_n !== 1 || r.len !== 80) begin
            n_errs++; $display("FAIL prescale_mid_change mism=%0d dv=%0d len=%0d exp 0 1 80", r.mism, r.dv_n, r.len);
        end
        run_frame(16, 8, 0, 0, 8'h44, 0, 0, 0, -1, r);
        n_checks++;
        if (r.mism !== 0 || r.len !== 160) begin
            n_errs++; $display("FAIL prescale_16_latched mism=%0d len=%0d exp 0 160", r.mism, r.len);
        end
        idle(1);
    endtask

    task automatic test_random;
        int ptab[6] = '{8, 16, 32, 12, 0, 20};
        res_t r;
        int p, pm, exp_len, exp_dv;
        bit p0, p1, gl, pe_, se;
        logic [DW-1:0] d;
        for (int i = 0; i < 24; i++) begin
            p  = ptab[$urandom_range(5)];
            pm = ptab[$urandom_range(5)];
            p0 = 1'($urandom_range(1));
            p1 = 1'($urandom_range(1));
            d  = DW'($urandom);
            gl = ($urandom_range(7) == 0);
            pe_ = ($urandom_range(3) == 0);
            se = ($urandom_range(3) == 0);
            run_frame(p, pm, p0, p1, d, gl, pe_, se, -1, r);
            exp_len = (p == 8 || p == 16 || p == 32) ? p : 8;
            exp_len = exp_len * (gl ? 1 : (2 + DW + int'(p1)));
            exp_dv  = (!gl && !se && !(p1 && pe_)) ? 1 : 0;
            n_checks++;
            if (r.mism !== 0) begin
                n_errs++; $display("FAIL rand%0d_cycles mism=%0d t=%0d got=%h exp=%h", i, r.mism, r.first_t, r.first_obs, r.first_exp);
            end
            n_checks++;
            if (r.len !== exp_len || r.dv_n !== exp_dv || r.deser_n !== (gl ? 0 : DW)) begin
                n_errs++; $display("FAIL rand%0d_frame len=%0d dv=%0d deser=%0d exp %0d %0d %0d",
                                   i, r.len, r.dv_n, r.deser_n, exp_len, exp_dv, gl ? 0 : DW);
            end
            idle($urandom_range(3));
        end
    endtask

    initial begin
        test_reset();
        test_basic_p8();
        test_parity_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_prescale();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
